// File: rtl/du_program_sequencer.sv
// Debug-unit sequencer for the PIPELINE DU port: loads a program into imem, runs or
// single-steps it, then streams the register file and data memory out as valid/ready words.
module du_program_sequencer #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       IMEM_AW     = 8,
    parameter int unsigned       REG_AW      = 5,
    parameter int unsigned       DUMP_WORDS  = 64,
    parameter int unsigned       RUN_TIMEOUT = 1024,
    parameter int unsigned       AUTO_HALT   = 1,
    parameter logic [DATA_W-1:0] HALT_WORD   = 32'hFC000000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [1:0]         i_cmd,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [DATA_W-1:0]  i_load_data,
    input  logic               i_load_valid,
    input  logic               i_load_last,
    output logic               o_load_ready,
    output logic               o_du_write_en,
    output logic [IMEM_AW-1:0] o_du_addr_wr,
    output logic [DATA_W-1:0]  o_du_data,
    output logic               o_du_read_en,
    input  logic               i_du_halt,
    output logic [REG_AW-1:0]  o_du_reg_addr,
    output logic [IMEM_AW-1:0] o_du_mem_addr,
    input  logic [DATA_W-1:0]  i_du_reg_data,
    input  logic [DATA_W-1:0]  i_du_mem_data,
    output logic [DATA_W-1:0]  o_dump_data,
    output logic               o_dump_valid,
    output logic               o_dump_last,
    input  logic               i_dump_ready,
    output logic [IMEM_AW-2:0] o_load_count,
    output logic               o_overflow,
    output logic               o_timeout
);
    localparam int unsigned NREGS = 2 ** REG_AW;
    localparam int unsigned DEPTH = 2 ** (IMEM_AW - 2);
    localparam int unsigned TOTAL = NREGS + DUMP_WORDS;
    localparam int unsigned PTR_W = IMEM_AW - 1;
    localparam int unsigned IDX_W = $clog2(TOTAL + 1);
    localparam int unsigned CNT_W = $clog2(RUN_TIMEOUT);

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_REGS = IDX_W'(NREGS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_HALT_APPEND = 3'd2,
        S_RUN         = 3'd3,
        S_STEP        = 3'd4,
        S_DUMP_REQ    = 3'd5,
        S_DUMP_WAIT   = 3'd6,
        S_DUMP_OUT    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               load_ready_q, load_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               rd_en_q, rd_en_d;
    logic [REG_AW-1:0]  reg_addr_q, reg_addr_d;
    logic [IMEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  dump_data_q, dump_data_d;
    logic               dump_valid_q, dump_valid_d;
    logic               dump_last_q, dump_last_d;

    function automatic logic [IMEM_AW-1:0] word_addr(input logic [PTR_W-1:0] ptr);
        return {ptr[IMEM_AW-3:0], 2'b00};
    endfunction

    function automatic logic [IMEM_AW-1:0] dump_mem_addr(input logic [IDX_W-1:0] idx);
        logic [31:0] off;
        off = 32'(idx) - 32'(NREGS);
        return IMEM_AW'(off << 2);
    endfunction

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        reg_addr_d   = reg_addr_q;
        mem_addr_d   = mem_addr_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    case (i_cmd)
                        2'd0: begin
                            state_d    = S_LOAD;
                            ptr_d      = '0;
                            overflow_d = 1'b0;
                        end
                        2'd1: begin
                            state_d   = S_RUN;
                            cnt_d     = '0;
                            timeout_d = 1'b0;
                        end
                        2'd2: begin
                            state_d = S_STEP;
                        end
                        2'd3: begin
                            state_d    = S_DUMP_REQ;
                            idx_d      = '0;
                            reg_addr_d = '0;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (i_load_valid && load_ready_q) begin
                    // A full imem still accepts words so the host stream drains to its last word.
                    if (ptr_q == PTR_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_addr(ptr_q);
                        wr_data_d = i_load_data;
                        ptr_d     = ptr_q + PTR_W'(1);
                    end
                    if (i_load_last) begin
                        if ((AUTO_HALT != 0) && (i_load_data != HALT_WORD) && (ptr_q < PTR_LAST)) begin
                            state_d = S_HALT_APPEND;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_HALT_APPEND: begin
                wr_en_d   = 1'b1;
                wr_addr_d = word_addr(ptr_q);
                wr_data_d = HALT_WORD;
                ptr_d     = ptr_q + PTR_W'(1);
                state_d   = S_IDLE;
            end
            S_RUN: begin
                // Halt takes priority over a timeout landing on the same cycle.
                if (i_du_halt) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            S_DUMP_REQ: begin
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (idx_q < IDX_REGS) begin
                    dump_data_d = i_du_reg_data;
                end else begin
                    dump_data_d = i_du_mem_data;
                end
                dump_valid_d = 1'b1;
                dump_last_d  = (idx_q == IDX_LAST);
                state_d      = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (i_dump_ready) begin
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                    if (dump_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_DUMP_REQ;
                        if (idx_d < IDX_REGS) begin
                            reg_addr_d = REG_AW'(idx_d);
                        end else begin
                            mem_addr_d = dump_mem_addr(idx_d);
                        end
                    end
                end else begin
                    state_d = S_DUMP_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d      = (state_d == S_RUN) || (state_d == S_STEP);
        cmd_ready_d  = (state_d == S_IDLE);
        load_ready_d = (state_d == S_LOAD);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            load_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            cmd_ready_q  <= cmd_ready_d;
            load_ready_q <= load_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            reg_addr_q   <= reg_addr_d;
            mem_addr_q   <= mem_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_load_ready  = load_ready_q;
    assign o_du_write_en = wr_en_q;
    assign o_du_addr_wr  = wr_addr_q;
    assign o_du_data     = wr_data_q;
    assign o_du_read_en  = rd_en_q;
    assign o_du_reg_addr = reg_addr_q;
    assign o_du_mem_addr = mem_addr_q;
    assign o_dump_data   = dump_data_q;
    assign o_dump_valid  = dump_valid_q;
    assign o_dump_last   = dump_last_q;
    assign o_load_count  = ptr_q;
    assign o_overflow    = overflow_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_du_program_sequencer.sv
// Self-checking bench for du_program_sequencer: random programs, run/step lengths and
// dump back-pressure compared against a behavioural model of imem writes and dump order.
module tb_du_program_sequencer;
    localparam int          DW     = 32;
    localparam int          AW     = 8;
    localparam int          RAW    = 5;
    localparam int          DWORDS = 64;
    localparam int          RTO    = 16;
    localparam int          DEPTH  = 64;
    localparam int          NREGS  = 32;
    localparam int          TOTAL  = NREGS + DWORDS;
    localparam logic [31:0] HALT   = 32'hFC000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    i_cmd = 2'd0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [DW-1:0] i_load_data = '0;
    logic          i_load_valid = 1'b0;
    logic          i_load_last = 1'b0;
    logic          o_load_ready;
    logic          o_du_write_en;
    logic [AW-1:0] o_du_addr_wr;
    logic [DW-1:0] o_du_data;
    logic          o_du_read_en;
    logic          i_du_halt = 1'b0;
    logic [RAW-1:0] o_du_reg_addr;
    logic [AW-1:0] o_du_mem_addr;
    logic [DW-1:0] i_du_reg_data = '0;
    logic [DW-1:0] i_du_mem_data = '0;
    logic [DW-1:0] o_dump_data;
    logic          o_dump_valid;
    logic          o_dump_last;
    logic          i_dump_ready = 1'b0;
    logic [AW-2:0] o_load_count;
    logic          o_overflow;
    logic          o_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] regs [NREGS];
    logic [31:0] memw [DWORDS];
    logic [31:0] prog [$];
    logic [AW+DW-1:0] wq [$];
    bit overlap = 1'b0;

    du_program_sequencer #(
        .DATA_W(DW), .IMEM_AW(AW), .REG_AW(RAW), .DUMP_WORDS(DWORDS),
        .RUN_TIMEOUT(RTO), .AUTO_HALT(1), .HALT_WORD(HALT)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_load_data(i_load_data), .i_load_valid(i_load_valid), .i_load_last(i_load_last),
        .o_load_ready(o_load_ready),
        .o_du_write_en(o_du_write_en), .o_du_addr_wr(o_du_addr_wr), .o_du_data(o_du_data),
        .o_du_read_en(o_du_read_en), .i_du_halt(i_du_halt),
        .o_du_reg_addr(o_du_reg_addr), .o_du_mem_addr(o_du_mem_addr),
        .i_du_reg_data(i_du_reg_data), .i_du_mem_data(i_du_mem_data),
        .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .o_dump_last(o_dump_last),
        .i_dump_ready(i_dump_ready),
        .o_load_count(o_load_count), .o_overflow(o_overflow), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    // Register file and data memory with one-cycle read latency.
    always @(posedge clk) begin
        i_du_reg_data <= regs[o_du_reg_addr];
        i_du_mem_data <= memw[o_du_mem_addr[7:2]];
    end

    // Capture every imem write and flag any cycle with write and run enables together.
    always @(negedge clk) begin
        if (o_du_write_en) wq.push_back({o_du_addr_wr, o_du_data});
        if (o_du_write_en && o_du_read_en) overlap = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (o_cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_cmd_ready"}, 64'(ok), 64'd1);
        i_cmd = c;
        i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic load_prog(input string tag);
        logic [AW+DW-1:0] exp_q [$];
        int n;
        n = prog.size();
        exp_q = {};
        for (int i = 0; i < n; i++)
            if (i < DEPTH) exp_q.push_back({8'(i * 4), prog[i]});
        if (prog[n-1] != HALT && n < DEPTH) exp_q.push_back({8'(n * 4), HALT});
        wq.delete();
        do_cmd(2'd0, tag);
        chk({tag, "_load_ready"}, 64'(o_load_ready), 64'd1);
        chk({tag, "_count_clr"}, 64'(o_load_count), 64'd0);
        for (int i = 0; i < n; i++) begin
            i_load_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            i_load_valid = 1'b1;
            i_load_data  = prog[i];
            i_load_last  = (i == n - 1);
            @(negedge clk);
        end
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
        chk({tag, "_load_ready_off"}, 64'(o_load_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < wq.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(exp_q[i]));
        chk({tag, "_count"}, 64'(o_load_count), 64'(exp_q.size()));
        chk({tag, "_overflow"}, 64'(o_overflow), 64'(n > DEPTH));
        chk({tag, "_idle"}, 64'(o_cmd_ready), 64'd1);
    endtask

    task automatic run_chk(input logic [1:0] c, input int halt_at, input string tag);
        logic to0;
        int n, exp_n;
        logic exp_to;
        to0 = o_timeout;
        do_cmd(c, tag);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!o_du_read_en) break;
            n++;
            if (halt_at != 0 && n == halt_at) i_du_halt = 1'b1;
            @(negedge clk);
            i_du_halt = 1'b0;
        end
        if (c == 2'd1) begin
            exp_n  = (halt_at >= 1 && halt_at <= RTO) ? halt_at : RTO;
            exp_to = !(halt_at >= 1 && halt_at <= RTO);
        end else begin
            exp_n  = 1;
            exp_to = to0;
        end
        chk({tag, "_run_cycles"}, 64'(n), 64'(exp_n));
        chk({tag, "_timeout"}, 64'(o_timeout), 64'(exp_to));
        chk({tag, "_idle"}, 64'(o_cmd_ready), 64'd1);
    endtask

    task automatic dump_chk(input bit rand_ready, input string tag);
        int k, cycles;
        bit done, stall;
        logic [31:0] held, exp;
        k = 0; cycles = 0; done = 1'b0; stall = 1'b0; held = '0;
        do_cmd(2'd3, tag);
        for (int c = 0; c < 2000 && !done; c++) begin
            i_dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycles++;
            if (stall) chk({tag, "_stable"}, {31'd0, o_dump_valid, o_dump_data}, {32'd1, held});
            if (o_dump_valid && i_dump_ready) begin
                exp = (k < NREGS) ? regs[k] : memw[k - NREGS];
                chk($sformatf("%s_word%0d", tag, k), 64'(o_dump_data), 64'(exp));
                chk($sformatf("%s_last%0d", tag, k), 64'(o_dump_last), 64'(k == TOTAL - 1));
                if (o_dump_last) done = 1'b1;
                k++;
                stall = 1'b0;
            end else if (o_dump_valid) begin
                stall = 1'b1;
                held  = o_dump_data;
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
        end
        i_dump_ready = 1'b0;
        chk({tag, "_nwords"}, 64'(k), 64'(TOTAL));
        if (!rand_ready) chk({tag, "_cycles"}, 64'(cycles), 64'(3 * TOTAL));
        chk({tag, "_valid_off"}, 64'(o_dump_valid), 64'd0);
        chk({tag, "_idle"}, 64'(o_cmd_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        for (int i = 0; i < DWORDS; i++) memw[i] = $urandom;

        #23;
        chk("rst_outputs",
            {o_cmd_ready, o_load_ready, o_du_write_en, o_du_read_en, o_dump_valid, o_dump_last,
             o_overflow, o_timeout, o_load_count, o_du_reg_addr},
            64'd0);
        chk("rst_buses", {o_du_addr_wr, o_du_mem_addr, o_du_data}, 64'd0);
        chk("rst_dump_data", 64'(o_dump_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 64'(o_cmd_ready), 64'd1);

        prog = '{32'h2443FFFF, 32'hFC000000};
        load_prog("ld_halt_given");
        prog = '{32'h2443FFFF};
        load_prog("ld_auto_halt");
        for (int r = 0; r < 4; r++) begin
            prog = {};
            for (int i = 0; i < $urandom_range(1, 8); i++) prog.push_back($urandom);
            if ($urandom_range(0, 1) != 0) prog[prog.size()-1] = HALT;
            load_prog($sformatf("ld_rand%0d", r));
        end
        prog = {};
        for (int i = 0; i < 63; i++) prog.push_back($urandom | 32'h1);
        load_prog("ld_63_append");
        prog.push_back(32'h12345679);
        load_prog("ld_64_full");
        prog.push_back(32'h0BADF00D);
        prog.push_back(32'h00C0FFEE);
        load_prog("ld_66_overflow");
        prog = '{32'h11111111, 32'h22222222, 32'h33333333};
        load_prog("ld_ovf_clear");

        run_chk(2'd1, 7, "run_halt7");
        for (int r = 0; r < 3; r++) run_chk(2'd1, $urandom_range(1, 15), $sformatf("run_rand%0d", r));
        run_chk(2'd1, 16, "run_halt_vs_timeout");
        run_chk(2'd1, 0, "run_timeout");
        run_chk(2'd2, 0, "step_sticky_to");
        run_chk(2'd2, 1, "step_halt_ignored");
        run_chk(2'd1, 1, "run_halt1");

        dump_chk(1'b1, "dump_rand_ready");
        dump_chk(1'b0, "dump_full_rate");

        prog = {};
        for (int i = 0; i < 65; i++) prog.push_back($urandom);
        load_prog("ld_pre_reset");
        do_cmd(2'd1, "run_reset");
        repeat (3) @(negedge clk);
        chk("run_before_reset", 64'(o_du_read_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_run", {o_du_read_en, o_cmd_ready, o_overflow, o_timeout, o_du_write_en, o_load_count},
            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_recover", 64'(o_cmd_ready), 64'd1);
        run_chk(2'd2, 0, "step_after_reset");

        chk("no_write_read_overlap", 64'(overlap), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
